// File: rtl/car_alarm_controller_pkg.sv
// ============================================================================
// car_alarm_controller_pkg : state codes and widths shared by the alarm blocks
// Revision: 1.0
// ============================================================================
`default_nettype none

package car_alarm_controller_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4,
        ST_REARM       = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alarm_timer.sv
// ============================================================================
// alarm_timer : loadable down-counter with zero flag for the alarm sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module alarm_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load wins over decrement; the counter never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/car_alarm_controller.sv
// ============================================================================
// car_alarm_controller : arm/disarm sequencing, siren timing, lights reminder
// Revision: 1.0
// ============================================================================
`default_nettype none

module car_alarm_controller
    import car_alarm_controller_pkg::*;
#(
    parameter int EXIT_CYCLES  = 4,
    parameter int ENTRY_CYCLES = 8,
    parameter int SIREN_CYCLES = 16,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ArmRequest,
    input  logic               DisarmRequest,
    input  logic               CarLightsOnSign,
    input  logic               OpenDoorSign,
    input  logic               IgnitionSignalOn,
    output logic               SirenOn,
    output logic               ArmedIndicator,
    output logic               LightsReminder,
    output logic [STATE_W-1:0] State,
    output logic [3:0]         TriggerCount
);

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_dec;
    logic             tmr_zero;
    logic [3:0]       next_count;
    logic             next_armed;

    alarm_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_DISARMED;
            SirenOn        <= 1'b0;
            ArmedIndicator <= 1'b0;
            LightsReminder <= 1'b0;
            TriggerCount   <= 4'd0;
        end else begin
            state          <= next_state;
            SirenOn        <= (next_state == ST_ALARM);
            ArmedIndicator <= next_armed;
            LightsReminder <= CarLightsOnSign & OpenDoorSign & ~IgnitionSignalOn;
            TriggerCount   <= next_count;
        end
    end

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        tmr_dec    = 1'b0;
        if (DisarmRequest) begin
            next_state = ST_DISARMED;
            tmr_load   = 1'b1;
        end else begin
            case (state)
                ST_DISARMED: begin
                    if (ArmRequest && !IgnitionSignalOn) begin
                        next_state = ST_EXIT_DELAY;
                        tmr_load   = 1'b1;
                        tmr_value  = EXIT_LOAD;
                    end
                end
                ST_EXIT_DELAY: begin
                    if (tmr_zero) next_state = ST_ARMED;
                    else          tmr_dec    = 1'b1;
                end
                ST_ARMED: begin
                    if (IgnitionSignalOn) begin
                        next_state = ST_ALARM;
                        tmr_load   = 1'b1;
                        tmr_value  = SIREN_LOAD;
                    end else if (OpenDoorSign) begin
                        next_state = ST_ENTRY_DELAY;
                        tmr_load   = 1'b1;
                        tmr_value  = ENTRY_LOAD;
                    end
                end
                ST_ENTRY_DELAY: begin
                    if (tmr_zero) begin
                        next_state = ST_ALARM;
                        tmr_load   = 1'b1;
                        tmr_value  = SIREN_LOAD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_ALARM: begin
                    if (tmr_zero) next_state = ST_REARM;
                    else          tmr_dec    = 1'b1;
                end
                ST_REARM: begin
                    if (!OpenDoorSign) next_state = ST_ARMED;
                end
                default: begin
                    next_state = ST_DISARMED;
                    tmr_load   = 1'b1;
                end
            endcase
        end
    end

    // Count entries into ALARM only, so a long siren dwell counts once.
    always_comb begin
        next_count = TriggerCount;
        if (DisarmRequest) begin
            next_count = 4'd0;
        end else if ((next_state == ST_ALARM) && (state != ST_ALARM) && (TriggerCount != 4'd15)) begin
            next_count = TriggerCount + 4'd1;
        end
    end

    assign next_armed = (next_state == ST_ARMED) || (next_state == ST_ENTRY_DELAY) ||
                        (next_state == ST_ALARM) || (next_state == ST_REARM);

    assign State = state;

endmodule

`default_nettype wire
